// File: rtl/digipot_spi_seq.sv
// digipot_spi_seq: shadowed multi-channel digipot writer sending round-robin SPI mode-0 frames.
// Define DIGIPOT_SPI_SEQ_READBACK_EN to add the rd_ch/rd_data shadow readback port.
module digipot_spi_seq #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 2,
    parameter int WIPER_W = 8,
    parameter int CLK_DIV = 2,
    parameter logic [WIPER_W-1:0] WIPER_RST = 'h80
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_ch,
    input  logic [WIPER_W-1:0] wr_data,
    output logic               busy,
    output logic               frame_done,
    output logic               spi_cs_n,
    output logic               spi_sclk,
    output logic               spi_mosi
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]  rd_ch,
    output logic [WIPER_W-1:0] rd_data
`endif
);
    localparam int FRAME_W = ADDR_W + WIPER_W;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_W);
    // The IDLE selection cycle completes the cs_n-high gap, so GAP itself is one cycle shorter.
    localparam int GAP_N = (CLK_DIV > 1) ? CLK_DIV - 1 : 1;
    localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;

    logic [1:0] state;
    logic [WIPER_W-1:0] shadow [NUM_CH];
    logic [NUM_CH-1:0] dirty, dirty_nxt;
    logic [ADDR_W-1:0] ptr, sel;
    logic [FRAME_W-1:0] frame;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic wr_hit, pick;

    assign wr_ready = !ARESET;
    assign wr_hit = wr_valid && wr_ready && ({1'b0, wr_ch} < NUM_CH_W);
    assign pick = (state == IDLE) && |dirty;
    assign busy = (state != IDLE) || |dirty;
    assign spi_cs_n = state != SHIFT;
    assign spi_sclk = (state == SHIFT) && (div_cnt >= DIV_W'(CLK_DIV));
    assign spi_mosi = (state == SHIFT) && frame[FRAME_W-1];

    // Scan downward so the nearest dirty channel after ptr wins.
    always_comb begin
        sel = ptr;
        for (int i = NUM_CH; i >= 1; i--)
            if (dirty[(int'(ptr) + i) % NUM_CH]) sel = ADDR_W'((int'(ptr) + i) % NUM_CH);
    end

    always_comb begin
        dirty_nxt = dirty;
        if (pick) dirty_nxt[sel] = 1'b0;
        if (wr_hit) dirty_nxt[wr_ch] = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            dirty <= '0;
            ptr <= ADDR_W'(NUM_CH - 1);
            frame <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= WIPER_RST;
        end else begin
            frame_done <= 1'b0;
            dirty <= dirty_nxt;
            if (wr_hit) shadow[wr_ch] <= wr_data;
            case (state)
                IDLE: if (pick) begin
                    frame <= {sel, shadow[sel]};
                    ptr <= sel;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state <= SHIFT;
                end
                SHIFT: if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        frame_done <= 1'b1;
                        state <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        frame <= frame << 1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                GAP: if (div_cnt == DIV_W'(GAP_N - 1)) state <= IDLE;
                     else div_cnt <= div_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rd_data <= '0;
        else rd_data <= ({1'b0, rd_ch} < NUM_CH_W) ? shadow[rd_ch] : '0;
    end
`endif
endmodule

// File: tb/tb_digipot_spi_seq.sv
// tb_digipot_spi_seq: random and directed checks of digipot_spi_seq against a frame-level model.
module tb_digipot_spi_seq;
    logic ACLK = 1'b0, ARESET = 1'b1;
    logic wr_valid = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_data = '0;
    logic wr_ready, busy, frame_done, spi_cs_n, spi_sclk, spi_mosi;
    logic o_valid = 1'b0;
    logic [2:0] o_ch = '0;
    logic [7:0] o_data = '0;
    logic o_ready, o_busy, o_done, o_cs_n, o_sclk, o_mosi;
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
    logic [1:0] rd_ch = '0;
    logic [7:0] rd_data;
    logic [2:0] o_rd_ch = '0;
    logic [7:0] o_rd_data;
`endif

    int n_tests = 0, n_fail = 0;
    int cyc = 0, fall_cyc = 0, w_cyc = 0, low_cnt = 0, hi_cnt = 0, nb = 0, fd_cnt = 0, frames = 0;
    int m_ptr, m_ch;
    logic [9:0] bits = '0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, o_bad = 1'b0;
    int gap_q[$];
    logic [9:0] exp_q[$], got_log[$];
    logic [7:0] m_sh [4];
    logic [3:0] m_dirty;

    digipot_spi_seq u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_ch(wr_ch), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi)
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
        , .rd_ch(rd_ch), .rd_data(rd_data)
`endif
    );

    digipot_spi_seq #(.NUM_CH(4), .ADDR_W(3)) u_oor (
        .ACLK(ACLK), .ARESET(ARESET), .wr_valid(o_valid), .wr_ready(o_ready),
        .wr_ch(o_ch), .wr_data(o_data), .busy(o_busy), .frame_done(o_done),
        .spi_cs_n(o_cs_n), .spi_sclk(o_sclk), .spi_mosi(o_mosi)
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
        , .rd_ch(o_rd_ch), .rd_data(o_rd_data)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: a cs_n fall is one selection, resolved before that edge's write.
    always begin
        @(posedge ACLK);
        #1;
        cyc++;
        if (ARESET) begin
            for (int i = 0; i < 4; i++) m_sh[i] = 8'h80;
            m_dirty = '0;
            m_ptr = 3;
            exp_q.delete();
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (!o_cs_n || o_busy) o_bad = 1'b1;
            if (frame_done) fd_cnt++;
            if (prev_cs && !spi_cs_n) begin
                fall_cyc = cyc;
                gap_q.push_back(hi_cnt);
                nb = 0;
                low_cnt = 0;
                bits = '0;
                m_ch = -1;
                for (int i = 4; i >= 1; i--) if (m_dirty[(m_ptr + i) % 4]) m_ch = (m_ptr + i) % 4;
                chk("sel_has_dirty", 32'(m_ch >= 0), 1);
                if (m_ch >= 0) begin
                    exp_q.push_back({2'(m_ch), m_sh[m_ch]});
                    m_dirty[m_ch] = 1'b0;
                    m_ptr = m_ch;
                end
            end
            if (!prev_cs && spi_cs_n) begin
                frames++;
                got_log.push_back(bits);
                chk("sclk_rises", nb, 10);
                chk("cs_low_cycles", low_cnt, 40);
                chk("done_at_end", 32'(frame_done), 1);
                if (exp_q.size() > 0) chk("frame", 32'(bits), 32'(exp_q.pop_front()));
                else chk("frame_expected", 0, 1);
                hi_cnt = 0;
            end
            if (!spi_cs_n) begin
                low_cnt++;
                if (spi_sclk && !prev_sclk) begin
                    bits = {bits[8:0], spi_mosi};
                    nb++;
                end
            end else begin
                hi_cnt++;
            end
            if (wr_valid && wr_ready) begin
                m_sh[wr_ch] = wr_data;
                m_dirty[wr_ch] = 1'b1;
            end
            prev_cs = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        @(negedge ACLK);
        wr_valid = 1'b1;
        wr_ch = ch;
        wr_data = d;
        w_cyc = cyc;
        @(negedge ACLK);
        wr_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames < n && k < 500) begin
            @(negedge ACLK);
            k++;
        end
        chk("frame_count", frames, n);
    endtask

    task automatic wait_cs_low();
        int k = 0;
        while (spi_cs_n && k < 100) begin
            @(negedge ACLK);
            k++;
        end
        chk("cs_low_seen", 32'(spi_cs_n), 0);
    endtask

    initial begin
        int f0, d0, k;
        repeat (3) @(negedge ACLK);
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_sclk", 32'(spi_sclk), 0);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(wr_ready), 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("ready", 32'(wr_ready), 1);
        chk("idle_busy", 32'(busy), 0);
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
        chk("rd_reset", 32'(rd_data), 32'h80);
`endif
        // Single write: latency, frame contents, one done pulse.
        d0 = fd_cnt;
        wr(2'd1, 8'h3C);
        chk("busy_after_wr", 32'(busy), 1);
        wait_frames(frames + 1);
        chk("latency", fall_cyc - w_cyc, 2);
        chk("frame_ch1", 32'(got_log[got_log.size() - 1]), 32'h13C);
        chk("done_pulses", fd_cnt - d0, 1);
        repeat (5) @(negedge ACLK);
        chk("busy_drained", 32'(busy), 0);
        // Back-to-back writes: round-robin order and 2-cycle gaps.
        got_log.delete();
        gap_q.delete();
        f0 = frames;
        @(negedge ACLK); wr_valid = 1'b1; wr_ch = 2'd3; wr_data = 8'h5A;
        @(negedge ACLK); wr_ch = 2'd0; wr_data = 8'hC3;
        @(negedge ACLK); wr_ch = 2'd2; wr_data = 8'h0F;
        @(negedge ACLK); wr_valid = 1'b0;
        wait_frames(f0 + 3);
        if (got_log.size() == 3 && gap_q.size() == 3) begin
            chk("rr_first", 32'(got_log[0]), 32'h35A);
            chk("rr_second", 32'(got_log[1]), 32'h0C3);
            chk("rr_third", 32'(got_log[2]), 32'h20F);
            chk("gap_1", gap_q[1], 2);
            chk("gap_2", gap_q[2], 2);
        end else chk("rr_frames", got_log.size(), 3);
        // Rewrite of the channel in flight.
        got_log.delete();
        f0 = frames;
        wr(2'd2, 8'h11);
        wait_cs_low();
        repeat (10) @(negedge ACLK);
        wr(2'd2, 8'h22);
        wait_frames(f0 + 2);
        if (got_log.size() == 2) begin
            chk("inflight_old", 32'(got_log[0]), 32'h211);
            chk("inflight_new", 32'(got_log[1]), 32'h222);
        end else chk("inflight_frames", got_log.size(), 2);
        // Reset mid-frame, landing while sclk is high.
        f0 = frames;
        d0 = fd_cnt;
        wr(2'd1, 8'h55);
        wait_cs_low();
        k = 0;
        while (!spi_sclk && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        chk("sclk_high_before_rst", 32'(spi_sclk), 1);
        ARESET = 1'b1;
        #1;
        chk("abort_cs_n", 32'(spi_cs_n), 1);
        chk("abort_sclk", 32'(spi_sclk), 0);
        chk("abort_mosi", 32'(spi_mosi), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (100) @(negedge ACLK);
        chk("abort_no_frame", frames, f0);
        chk("abort_no_done", fd_cnt, d0);
        chk("abort_busy_after", 32'(busy), 0);
`ifdef DIGIPOT_SPI_SEQ_READBACK_EN
        chk("rd_after_rst", 32'(rd_data), 32'h80);
        wr(2'd0, 8'hA5);
        chk("rd_before", 32'(rd_data), 32'h80);
        @(negedge ACLK);
        chk("rd_updated", 32'(rd_data), 32'hA5);
        wait_frames(frames + 1);
`endif
        // Out-of-range channel on the 3-bit-address instance.
        @(negedge ACLK);
        o_valid = 1'b1;
        o_ch = 3'd5;
        o_data = 8'h77;
        chk("oor_ready", 32'(o_ready), 1);
        @(negedge ACLK);
        o_valid = 1'b0;
        repeat (60) @(negedge ACLK);
        chk("oor_ignored", 32'(o_bad), 0);
        @(negedge ACLK);
        o_valid = 1'b1;
        o_ch = 3'd3;
        @(negedge ACLK);
        o_valid = 1'b0;
        k = 0;
        while (o_cs_n && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        chk("oor_inrange_sent", 32'(o_cs_n), 0);
        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            wr_valid = ($urandom_range(0, 4) == 0);
            wr_ch = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
        end
        @(negedge ACLK);
        wr_valid = 1'b0;
        k = 0;
        while ((busy || !spi_cs_n) && k < 5000) begin
            @(negedge ACLK);
            k++;
        end
        chk("rand_drain", 32'(busy), 0);
        chk("rand_exp_left", exp_q.size(), 0);
        chk("done_vs_frames", fd_cnt, frames);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
